arbiter_puf_engine: RTL

- Parametrised successor to the fixed 3-stage arbiter delay line.
- Contains an N-stage switch-box delay line. It accepts a challenge over a valid/ready handshake and launches a race pulse VOTES times per response bit.
- An external arbiter cell (hard macro) samples the race; this block majority-votes its decision into each bit.
- Produces a RESP_BITS-wide response plus a stability flag, for the key-generation/authentication logic above it.

---
 rtl/puf_pkg.sv | 34 +++
 rtl/puf_delay_line.sv | 40 ++++
 rtl/arbiter_puf_engine.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/puf_pkg.sv
// Purpose: shared types and helpers for the arbiter PUF engine.
// Latency: n/a (types and a combinational rotate helper only).
// Backpressure: n/a.
package puf_pkg;

   // Widest challenge the rotate helper handles; STAGES must not exceed this.
   localparam int PUF_MAX_W   = 64;
   localparam int PUF_IDX_W   = $clog2(PUF_MAX_W);

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      SETTLE,
      SAMPLE,
      RELAX,
      NEXT,
      DONE
   } puf_state_t;

   // Rotate the low w bits of v left by k; bits at and above w come back as 0.
   function automatic logic [PUF_MAX_W-1:0] rotl(input logic [PUF_MAX_W-1:0] v,
                                                 input int unsigned          w,
                                                 input int unsigned          k);
      logic [PUF_MAX_W-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < PUF_MAX_W; i++) begin
         if (i < w) begin
            r[PUF_IDX_W'((i + k) % w)] = v[PUF_IDX_W'(i)];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/puf_delay_line.sv
// Purpose: STAGES-deep switch-box race line; each stage passes or crosses the two paths.
// Latency: purely combinational from pulse/sel to top/bot.
// Backpressure: none.
// Ports: pulse (race launch), sel[STAGES] (per-stage cross select), top/bot (path outputs).

// 2:1 mux cell used for every switch-box leg.
module puf_mux2 (
   input  logic a,
   input  logic b,
   input  logic sel,
   output logic y
);
   assign y = sel ? b : a;
endmodule

module puf_delay_line #(
   parameter int STAGES = 8
) (
   input  logic              pulse,
   input  logic [STAGES-1:0] sel,
   output logic              top,
   output logic              bot
);

   logic [STAGES:0] top_w;
   logic [STAGES:0] bot_w;

   // Both paths start from the same edge; only the physical delays differ.
   assign top_w[0] = pulse;
   assign bot_w[0] = pulse;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      puf_mux2 u_top (.a(top_w[i]), .b(bot_w[i]), .sel(sel[i]), .y(top_w[i+1]));
      puf_mux2 u_bot (.a(bot_w[i]), .b(top_w[i]), .sel(sel[i]), .y(bot_w[i+1]));
   end

   assign top = top_w[STAGES];
   assign bot = bot_w[STAGES];

endmodule

// File: rtl/arbiter_puf_engine.sv
// Purpose: launches VOTES races per response bit through the delay line and majority-votes the arbiter.
// Latency: RESP_BITS*(VOTES*(2+2*SETTLE_CYC)+1)+1 cycles from challenge accept to oresp_valid.
// Backpressure: och_ready low while busy; response held in DONE until iresp_ready.
// Ports: ichallenge/ich_valid/och_ready (challenge in), orace_top/orace_bot (to arbiter macro),
//        iarb (arbiter decision), oresp/ounstable/oresp_valid/iresp_ready (response out).
module arbiter_puf_engine
   import puf_pkg::*;
#(
   parameter int STAGES     = 8,
   parameter int RESP_BITS  = 4,
   parameter int VOTES      = 5,
   parameter int SETTLE_CYC = 4
) (
   input  logic                 iclk,
   input  logic                 irst_n,
   input  logic [STAGES-1:0]    ichallenge,
   input  logic                 ich_valid,
   output logic                 och_ready,
   output logic                 orace_top,
   output logic                 orace_bot,
   input  logic                 iarb,
   output logic [RESP_BITS-1:0] oresp,
   output logic                 ounstable,
   output logic                 oresp_valid,
   input  logic                 iresp_ready
);

   localparam int CW = $clog2(VOTES + 1);
   localparam int KW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
   localparam int TW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   puf_state_t           state;
   puf_state_t           state_nxt;

   logic [STAGES-1:0]    challenge_q;
   logic [STAGES-1:0]    sel;
   logic                 pulse;
   logic [CW-1:0]        votes;
   logic [CW-1:0]        ones;
   logic [KW-1:0]        bit_idx;
   logic [TW-1:0]        tmr;
   logic [RESP_BITS-1:0] resp_acc;
   logic                 unst_acc;
   logic [RESP_BITS-1:0] resp_q;
   logic                 unst_q;

   logic                 tmr_last;
   logic                 votes_done;
   logic                 bit_last;
   logic [PUF_MAX_W-1:0] ch_ext;
   logic [STAGES-1:0]    rot_next;

   assign tmr_last   = (tmr == TW'(SETTLE_CYC - 1));
   assign votes_done = (votes == CW'(VOTES));
   assign bit_last   = (bit_idx == KW'(RESP_BITS - 1));

   always_comb begin
      ch_ext = '0;
      ch_ext[STAGES-1:0] = challenge_q;
   end

   // Stage select for the upcoming bit: captured challenge rotated by bit_idx+1.
   assign rot_next = STAGES'(rotl(ch_ext, STAGES, 32'(bit_idx) + 32'd1));

   // ---------------- state register ----------------
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (ich_valid) state_nxt = LAUNCH;
         LAUNCH:  state_nxt = SETTLE;
         SETTLE:  if (tmr_last) state_nxt = SAMPLE;
         SAMPLE:  state_nxt = RELAX;
         RELAX:   if (tmr_last) state_nxt = votes_done ? NEXT : LAUNCH;
         NEXT:    state_nxt = bit_last ? DONE : LAUNCH;
         DONE:    if (iresp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- outputs ----------------
   always_comb begin
      och_ready   = (state == IDLE);
      oresp_valid = (state == DONE);
   end

   assign oresp     = resp_q;
   assign ounstable = unst_q;

   // ---------------- datapath ----------------
   // Votes accumulate in resp_acc/unst_acc; oresp only moves when DONE is entered,
   // so the consumer never sees a half-built response.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         challenge_q <= '0;
         sel         <= '0;
         pulse       <= 1'b0;
         votes       <= '0;
         ones        <= '0;
         bit_idx     <= '0;
         tmr         <= '0;
         resp_acc    <= '0;
         unst_acc    <= 1'b0;
         resp_q      <= '0;
         unst_q      <= 1'b0;
      end else begin
         // One timer serves both the settle and relax windows.
         if ((state == SETTLE || state == RELAX) && !tmr_last) begin
            tmr <= tmr + TW'(1);
         end else begin
            tmr <= '0;
         end

         case (state)
            IDLE: begin
               if (ich_valid) begin
                  challenge_q <= ichallenge;
                  sel         <= ichallenge;
                  bit_idx     <= '0;
                  votes       <= '0;
                  ones        <= '0;
                  resp_acc    <= '0;
                  unst_acc    <= 1'b0;
               end
            end
            LAUNCH: pulse <= 1'b1;
            SAMPLE: begin
               ones  <= ones + CW'(iarb);
               votes <= votes + CW'(1);
               pulse <= 1'b0;
            end
            RELAX: begin
               if (tmr_last && votes_done) begin
                  resp_acc[bit_idx] <= (ones > CW'(VOTES / 2));
                  unst_acc <= unst_acc | ((ones != '0) && (ones != CW'(VOTES)));
               end
            end
            NEXT: begin
               if (bit_last) begin
                  resp_q <= resp_acc;
                  unst_q <= unst_acc;
               end else begin
                  bit_idx <= bit_idx + KW'(1);
                  sel     <= rot_next;
                  votes   <= '0;
                  ones    <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   puf_delay_line #(
      .STAGES (STAGES)
   ) u_line (
      .pulse (pulse),
      .sel   (sel),
      .top   (orace_top),
      .bot   (orace_bot)
   );

endmodule
